// File: rtl/weight_update_sequencer.sv
// Steps through NUM_WEIGHTS buffer entries: read old weight and gradient, hand them to the
// update unit, wait for its result (bounded by TIMEOUT) and write it back; all outputs registered.
module weight_update_sequencer #(
  parameter int NUM_WEIGHTS = 16,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic [15:0]       lr_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [15:0]       w_rd_data_in,
  input  logic [15:0]       g_rd_data_in,
  output logic [15:0]       lr_out,
  output logic [15:0]       W_old_out,
  output logic [15:0]       grad_out,
  output logic              grad_descent_start_out,
  input  logic [15:0]       W_updated_in,
  input  logic              grad_descent_done_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [15:0]       wr_data_out
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TMO      = TW'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [TW-1:0]     wait_cnt_q;
  logic              done_q, err_q, rd_en_q, gd_start_q, wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [15:0]       lr_q, w_old_q, grad_q, wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      gd_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      lr_q       <= '0;
      w_old_q    <= '0;
      grad_q     <= '0;
      wr_data_q  <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      rd_en_q    <= 1'b0;
      gd_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            lr_q      <= lr_in;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            state_q   <= S_READ;
          end
        end
        S_READ: state_q <= S_ISSUE;
        S_ISSUE: begin
          w_old_q    <= w_rd_data_in;
          grad_q     <= g_rd_data_in;
          gd_start_q <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (grad_descent_done_in) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= W_updated_in;
            state_q   <= S_WRITE;
          end else if (wait_cnt_q == TMO) begin
            // Update unit never answered: abandon the pass without writing.
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q     <= idx_q + 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= idx_q + 1'b1;
            state_q   <= S_READ;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_out               = (state_q != S_IDLE);
  assign done_out               = done_q;
  assign err_out                = err_q;
  assign rd_en_out              = rd_en_q;
  assign rd_addr_out            = rd_addr_q;
  assign lr_out                 = lr_q;
  assign W_old_out              = w_old_q;
  assign grad_out               = grad_q;
  assign grad_descent_start_out = gd_start_q;
  assign wr_en_out              = wr_en_q;
  assign wr_addr_out            = wr_addr_q;
  assign wr_data_out            = wr_data_q;

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Scoreboard bench: two sequencers (4 weights and 1 weight) driven by behavioural buffers and
// update-unit responders; a per-DUT monitor pops expected operands, writes and done events.
module tb_weight_update_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-weight instance
  logic        a_start, a_busy, a_done, a_err, a_rd_en, a_gds, a_gdd, a_wr_en;
  logic [3:0]  a_rd_addr, a_wr_addr;
  logic [15:0] a_lr, a_wrd, a_grd, a_lr_o, a_wold, a_grad, a_wupd, a_wr_data;
  // 1-weight instance
  logic        b_start, b_busy, b_done, b_err, b_rd_en, b_gds, b_gdd, b_wr_en;
  logic [0:0]  b_rd_addr, b_wr_addr;
  logic [15:0] b_lr, b_wrd, b_grd, b_lr_o, b_wold, b_grad, b_wupd, b_wr_data;

  weight_update_sequencer #(.NUM_WEIGHTS(4), .ADDR_W(4), .TIMEOUT(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_in(a_start), .lr_in(a_lr), .busy_out(a_busy),
    .done_out(a_done), .err_out(a_err), .rd_en_out(a_rd_en), .rd_addr_out(a_rd_addr),
    .w_rd_data_in(a_wrd), .g_rd_data_in(a_grd), .lr_out(a_lr_o), .W_old_out(a_wold),
    .grad_out(a_grad), .grad_descent_start_out(a_gds), .W_updated_in(a_wupd),
    .grad_descent_done_in(a_gdd), .wr_en_out(a_wr_en), .wr_addr_out(a_wr_addr),
    .wr_data_out(a_wr_data));

  weight_update_sequencer #(.NUM_WEIGHTS(1), .ADDR_W(1), .TIMEOUT(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_in(b_start), .lr_in(b_lr), .busy_out(b_busy),
    .done_out(b_done), .err_out(b_err), .rd_en_out(b_rd_en), .rd_addr_out(b_rd_addr),
    .w_rd_data_in(b_wrd), .g_rd_data_in(b_grd), .lr_out(b_lr_o), .W_old_out(b_wold),
    .grad_out(b_grad), .grad_descent_start_out(b_gds), .W_updated_in(b_wupd),
    .grad_descent_done_in(b_gdd), .wr_en_out(b_wr_en), .wr_addr_out(b_wr_addr),
    .wr_data_out(b_wr_data));

  logic [15:0] w_mem [4];
  logic [15:0] g_mem [4];
  localparam logic [15:0] B_W = 16'h0010;
  localparam logic [15:0] B_G = 16'h0003;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Update-unit responders and buffers with 1-cycle read latency
  int a_delay = 1;
  bit a_stray = 0;
  int rc_a, rc_b;
  bit nxt_a, rdp_a, nxt_b, rdp_b;
  logic [3:0]  ra_a;
  logic [15:0] res_a, res_b;

  initial begin
    rc_a = 0; a_gdd = 0; a_wupd = 0; a_wrd = 16'hDEAD; a_grd = 16'hBEEF;
    forever begin
      @(negedge clk);
      nxt_a = 0; rdp_a = a_rd_en; ra_a = a_rd_addr;
      res_a = a_wold - a_lr_o * a_grad;
      if (!rst_n) rc_a = 0;
      else begin
        if (a_gds && a_delay > 0) rc_a = a_delay;
        if (rc_a > 0) begin rc_a--; if (rc_a == 0) nxt_a = 1; end
        if (a_stray && a_wr_en) nxt_a = 1;
      end
      @(posedge clk); #1;
      a_gdd  = nxt_a;
      a_wupd = nxt_a ? res_a : 16'h0;
      a_wrd  = rdp_a ? w_mem[ra_a[1:0]] : 16'hDEAD;
      a_grd  = rdp_a ? g_mem[ra_a[1:0]] : 16'hBEEF;
    end
  end

  initial begin
    b_gdd = 0; b_wupd = 0; b_wrd = 16'hDEAD; b_grd = 16'hBEEF;
    forever begin
      @(negedge clk);
      nxt_b = rst_n && b_gds; rdp_b = b_rd_en;
      res_b = b_wold - b_lr_o * b_grad;
      @(posedge clk); #1;
      b_gdd  = nxt_b;
      b_wupd = nxt_b ? res_b : 16'h0;
      b_wrd  = rdp_b ? B_W : 16'hDEAD;
      b_grd  = rdp_b ? B_G : 16'hBEEF;
    end
  end

  // Scoreboards and monitors
  logic [47:0] exp_op_a[$], exp_op_b[$];
  logic [19:0] exp_wr_a[$], exp_wr_b[$];
  logic [32:0] exp_dn_a[$], exp_dn_b[$];
  logic [47:0] cur_a, cur_b;

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++; errors++;
    $display("FAIL %s actual=%0h required=no event", nm, act);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (a_gds) begin
      if (exp_op_a.size() == 0) unexpected("a_start_pulse", {a_lr_o, a_wold, a_grad});
      else begin cur_a = exp_op_a.pop_front(); chk("a_operands", {a_lr_o, a_wold, a_grad}, cur_a); end
    end
    if (a_wr_en) begin
      if (exp_wr_a.size() == 0) unexpected("a_write", {a_wr_addr, a_wr_data});
      else begin
        chk("a_write", {a_wr_addr, a_wr_data}, exp_wr_a.pop_front());
        chk("a_operands_held", {a_lr_o, a_wold, a_grad}, cur_a);
      end
    end
    if (a_done) begin
      if (exp_dn_a.size() == 0) unexpected("a_done", {cyc, a_err});
      else chk("a_done_cycle_err", {cyc, a_err}, exp_dn_a.pop_front());
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (b_gds) begin
      if (exp_op_b.size() == 0) unexpected("b_start_pulse", {b_lr_o, b_wold, b_grad});
      else begin cur_b = exp_op_b.pop_front(); chk("b_operands", {b_lr_o, b_wold, b_grad}, cur_b); end
    end
    if (b_wr_en) begin
      if (exp_wr_b.size() == 0) unexpected("b_write", {b_wr_addr, b_wr_data});
      else chk("b_write", {3'b000, b_wr_addr, b_wr_data}, exp_wr_b.pop_front());
    end
    if (b_done) begin
      if (exp_dn_b.size() == 0) unexpected("b_done", {cyc, b_err});
      else chk("b_done_cycle_err", {cyc, b_err}, exp_dn_b.pop_front());
    end
  end

  task automatic start_a(input logic [15:0] lr);
    a_lr = lr; a_start = 1; c0 = cyc;
    tick();
    a_start = 0;
  endtask

  task automatic expect_a(input logic [15:0] lr, input int n_op, input int n_wr,
                          input int dcyc, input bit err, input bit has_done);
    logic [15:0] d;
    for (int i = 0; i < n_op; i++) exp_op_a.push_back({lr, w_mem[i], g_mem[i]});
    for (int i = 0; i < n_wr; i++) begin
      d = w_mem[i] - lr * g_mem[i];
      exp_wr_a.push_back({4'(i), d});
    end
    if (has_done) exp_dn_a.push_back({dcyc, err});
  endtask

  task automatic drain_a(input int lim);
    int n = 0;
    while ((exp_op_a.size() != 0 || exp_wr_a.size() != 0 || exp_dn_a.size() != 0 || a_busy)
           && n < lim) begin
      tick(); n++;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL a_drain actual=%0d cycles required=<%0d", n, lim);
    end
  endtask

  task automatic check_zero_a(input string nm);
    chk({nm, "_ctl"}, {a_busy, a_done, a_err, a_rd_en, a_gds, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data}, 0);
    chk({nm, "_ops"}, {a_lr_o, a_wold, a_grad}, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      w_mem[i] = 16'h0100 + 16'(i * 16'h0011);
      g_mem[i] = 16'(i + 1);
    end
    a_start = 0; a_lr = 0; b_start = 0; b_lr = 0;
    tick(2);
    check_zero_a("reset_a");
    chk("reset_b", {b_busy, b_done, b_err, b_rd_en, b_gds, b_wr_en, b_lr_o, b_wold, b_grad, b_wr_data}, 0);

    // Nominal pass, start accepted on first edge after reset release
    rst_n = 1;
    start_a(16'h0002);
    expect_a(16'h0002, 4, 4, c0 + 21, 1'b0, 1'b1);
    chk("a_busy_in_pass", a_busy, 1'b1);
    chk("a_rd_first", {a_rd_en, a_rd_addr}, 5'b1_0000);
    drain_a(60);
    chk("a_err_after_ok", a_err, 1'b0);

    // Responder silent: timeout
    a_delay = 0;
    start_a(16'h0007);
    expect_a(16'h0007, 1, 0, c0 + 19, 1'b1, 1'b1);
    wait_until(c0 + 23);
    chk("a_err_sticky", a_err, 1'b1);
    chk("a_idle_after_tmo", a_busy, 1'b0);

    // Restarts during READ/WAIT and during done_out are ignored
    a_delay = 1;
    start_a(16'h0002);
    chk("a_err_cleared", a_err, 1'b0);
    expect_a(16'h0002, 4, 4, c0 + 21, 1'b0, 1'b1);
    a_start = 1; tick(); a_start = 0; tick();
    a_start = 1; tick(); a_start = 0;
    wait_until(c0 + 21);
    a_start = 1; tick(); a_start = 0;
    chk("a_start_at_done_ignored", a_busy, 1'b0);
    tick();
    chk("a_still_idle", a_busy, 1'b0);
    drain_a(60);

    // Reset during WAIT of idx 2
    a_delay = 3;
    start_a(16'h0002);
    expect_a(16'h0002, 3, 2, 0, 1'b0, 1'b0);
    wait_until(c0 + 18);
    chk("a_q_before_rst", exp_op_a.size() + exp_wr_a.size(), 0);
    rst_n = 0;
    #1;
    check_zero_a("midpass_rst");
    tick(3);
    a_delay = 1;
    rst_n = 1;
    start_a(16'h0002);
    expect_a(16'h0002, 4, 4, c0 + 21, 1'b0, 1'b1);
    drain_a(60);

    // Slow responder with stray done_in in READ
    a_delay = 3; a_stray = 1;
    start_a(16'h0005);
    expect_a(16'h0005, 4, 4, c0 + 29, 1'b0, 1'b1);
    drain_a(80);
    a_stray = 0;

    // Single-weight instance
    b_lr = 16'h0002; b_start = 1; c0 = cyc;
    exp_op_b.push_back({16'h0002, 16'h0010, 16'h0003});
    exp_wr_b.push_back({4'h0, 16'h000A});
    exp_dn_b.push_back({c0 + 6, 1'b0});
    tick(); b_start = 0;
    tick(12);
    chk("b_idle", b_busy, 1'b0);

    chk("a_q_empty", exp_op_a.size() + exp_wr_a.size() + exp_dn_a.size(), 0);
    chk("b_q_empty", exp_op_b.size() + exp_wr_b.size() + exp_dn_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
